div_seq_ctrl: RTL

Sequencer that owns the shared restoring divider. It assembles operands A and B from hex keypad nibbles and fires a one-cycle start to the divider. It then waits for the divider's done, latches quotient and remainder, and presents them for the 7-segment display path. It sits between the keypad decoder and the divider core in the top-level divider design.

---
 rtl/div_seq_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - keypad operand entry and result sequencer for the shared restoring divider
// Optional feature: define DIV_TIMEOUT_EN to build the WAIT watchdog (TIMEOUT_CYCLES) and drive err_timeout.
module div_seq_ctrl #(
  parameter int OP_W           = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  input  logic              key_clear,
  output logic              div_start,
  output logic [OP_W-1:0]   div_a,
  output logic [OP_W-1:0]   div_b,
  input  logic              div_done,
  input  logic [OP_W-1:0]   div_q,
  input  logic [OP_W-1:0]   div_r,
  output logic [OP_W-1:0]   q_out,
  output logic [OP_W-1:0]   r_out,
  output logic              result_valid,
  output logic              err_div0,
  output logic              err_timeout,
  output logic [2*OP_W-1:0] disp_value
);

  localparam int NIBBLES = OP_W / 4;
  localparam int CNT_W   = $clog2(NIBBLES + 1);

  typedef enum logic [2:0] {
    S_ENTER_A,
    S_ENTER_B,
    S_START,
    S_WAIT,
    S_SHOW,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [OP_W-1:0]     a_q, a_d, b_q, b_d, q_q, q_d, r_q, r_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                start_q, start_d, valid_q, valid_d, div0_q, div0_d;
  logic [2*OP_W-1:0]   disp_q, disp_d;
  logic [OP_W+3:0]     a_cat, b_cat;
  logic                last_nibble;

`ifdef DIV_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0]     wdog_q, wdog_d;
  logic                to_q, to_d;
`endif

  assign a_cat       = {a_q, key_code};
  assign b_cat       = {b_q, key_code};
  assign last_nibble = (cnt_q == CNT_W'(NIBBLES - 1));

  // Next-state, operand, result and registered-output computation
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    div0_d  = div0_q;
`ifdef DIV_TIMEOUT_EN
    wdog_d  = wdog_q;
    to_d    = to_q;
`endif
    case (state_q)
      S_ENTER_A: begin
        if (key_valid) begin
          a_d = a_cat[OP_W-1:0];
          if (last_nibble) begin
            cnt_d   = '0;
            state_d = S_ENTER_B;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_ENTER_B: begin
        if (key_valid) begin
          b_d = b_cat[OP_W-1:0];
          if (last_nibble) begin
            cnt_d = '0;
            // Zero check sees the nibble that was just shifted in
            if (b_cat[OP_W-1:0] == '0) begin
              state_d = S_ERR;
              div0_d  = 1'b1;
            end else begin
              state_d = S_START;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_START: begin
        state_d = S_WAIT;
`ifdef DIV_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end
      S_WAIT: begin
`ifdef DIV_TIMEOUT_EN
        wdog_d = wdog_q + WD_W'(1);
`endif
        // A done on the limit cycle still wins over the watchdog
        if (div_done) begin
          q_d     = div_q;
          r_d     = div_r;
          state_d = S_SHOW;
        end
`ifdef DIV_TIMEOUT_EN
        else if (wdog_d == WD_W'(TIMEOUT_CYCLES)) begin
          state_d = S_ERR;
          to_d    = 1'b1;
        end
`endif
      end
      S_SHOW, S_ERR: begin
        // The key that leaves a result/error screen is the first nibble of a new A
        if (key_valid) begin
          q_d     = '0;
          r_d     = '0;
          b_d     = '0;
          a_d     = OP_W'(key_code);
          cnt_d   = (NIBBLES == 1) ? CNT_W'(0) : CNT_W'(1);
          state_d = (NIBBLES == 1) ? S_ENTER_B : S_ENTER_A;
        end
      end
      default: state_d = S_ENTER_A;
    endcase

    // Clear beats everything, including a key or done in the same cycle
    if (key_clear) begin
      state_d = S_ENTER_A;
      a_d     = '0;
      b_d     = '0;
      q_d     = '0;
      r_d     = '0;
      cnt_d   = '0;
    end

    if (state_d != S_ERR) begin
      div0_d = 1'b0;
`ifdef DIV_TIMEOUT_EN
      to_d   = 1'b0;
`endif
    end

    start_d = (state_d == S_START);
    valid_d = (state_d == S_SHOW);
    case (state_d)
      S_SHOW:  disp_d = {q_d, r_d};
      S_ERR:   disp_d = '1;
      default: disp_d = {a_d, b_d};
    endcase
  end

  // Single state register for the sequencer and its registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      div0_q  <= 1'b0;
      disp_q  <= '0;
`ifdef DIV_TIMEOUT_EN
      wdog_q  <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      valid_q <= valid_d;
      div0_q  <= div0_d;
      disp_q  <= disp_d;
`ifdef DIV_TIMEOUT_EN
      wdog_q  <= wdog_d;
      to_q    <= to_d;
`endif
    end
  end

  assign div_start    = start_q;
  assign div_a        = a_q;
  assign div_b        = b_q;
  assign q_out        = q_q;
  assign r_out        = r_q;
  assign result_valid = valid_q;
  assign err_div0     = div0_q;
  assign disp_value   = disp_q;
`ifdef DIV_TIMEOUT_EN
  assign err_timeout  = to_q;
`else
  assign err_timeout  = 1'b0;
`endif

endmodule
